adc_echo_packer: RTL
====================

Name: adc_echo_packer

Overview:
- Downstream consumer of the ultrasound acquisition FSM's FIFO_EN acquisition window.
- While FIFO_EN is high, captures one ADC sample per clock and packs two samples into each 32-bit word.
- Buffers the packed words in an internal first-word-fall-through FIFO and drains them through a valid/ready stream toward the readout/DMA path.
- Reports per-echo completion, words written and a sticky overflow flag.

Parameters:
- ADC_DATA_WIDTH, 12: ADC sample width. Legal range 1..16.
- DEPTH_LOG2, 4: log2 of internal FIFO depth in 32-bit words (default 16 words).
- COUNT_WIDTH, 32: width of WORD_COUNT.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  single-cycle pulse aligned with acquisition START; clears per-acquisition status.
- FIFO_EN  in  1  acquisition window from acquisition FSM; high = sample valid this cycle.
- ADC_DATA  in  ADC_DATA_WIDTH  ADC sample, sampled on CLK edge when FIFO_EN=1.
- OUT_DATA  out  32  packed word; [15:0] = earlier sample, [31:16] = later sample, each zero-extended.
- OUT_VALID  out  1  OUT_DATA valid (FIFO non-empty).
- OUT_READY  in  1  consumer accepts OUT_DATA when OUT_VALID & OUT_READY.
- WORD_COUNT  out  COUNT_WIDTH  words successfully written into FIFO since last START/RESET.
- OVERFLOW  out  1  sticky: at least one word dropped since last START/RESET.
- ECHO_DONE  out  1  one-cycle pulse at end of each FIFO_EN window.
- FIFO_LEVEL  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.

Behaviour:
- Reset (RESET=1 at edge): FIFO emptied; OUT_VALID=0; OUT_DATA=0; WORD_COUNT=0; OVERFLOW=0; ECHO_DONE=0; FIFO_LEVEL=0; half-word state=EMPTY; FIFO_EN_d=0. RESET overrides all other inputs, including mid-capture. The pending half-word is discarded.
- Packer states:
  - EMPTY: FIFO_EN=1 stores the sample in the low half and moves to HALF.
  - HALF: FIFO_EN=1 forms the word {sample_now, held_sample}, issues a push and returns to EMPTY.
- Window end: FIFO_EN_d is a registered copy of FIFO_EN. The edge with FIFO_EN_d=1 and FIFO_EN=0 is the end of the window. At that edge:
  - if the packer is in HALF, push {16'h0, held_sample} and go to EMPTY;
  - ECHO_DONE=1 for exactly that one cycle.
- Push latency: a word pushed at edge N is visible on OUT_DATA with OUT_VALID=1 after edge N (first-word fall-through), provided the FIFO was empty.
- Push while full with no same-edge pop: the word is dropped, OVERFLOW<=1, WORD_COUNT unchanged, and FIFO contents are untouched.
- Push while full with a same-edge pop: the push succeeds and the level stays full.
- Simultaneous push and pop at any level: both occur; level unchanged. Pop on an empty FIFO cannot occur because OUT_VALID=0.
- WORD_COUNT increments by 1 per successful push and wraps modulo 2^COUNT_WIDTH.
- Stream rule: OUT_DATA and OUT_VALID hold stable while OUT_VALID=1 and OUT_READY=0.
- START=1 at an edge: WORD_COUNT<=0, OVERFLOW<=0, packer<=EMPTY (pending half discarded). FIFO contents and the output stream are not affected. If FIFO_EN=1 on the same edge, that sample is captured as the first half of the new acquisition. A push on the same edge still enters the FIFO, but WORD_COUNT reads 0 afterwards (START wins for counters).
- FIFO_EN re-asserted immediately after a window end starts a new echo with the packer in EMPTY.
- Samples beyond 16 bits are not supported (ADC_DATA_WIDTH > 16 is illegal).

Test Plan:
- Even window: RESET, START, FIFO_EN high 10 cycles with ADC_DATA=1..10, OUT_READY=1.
  - Required: 5 words 0x00020001, 0x00040003, ..., 0x000A0009 in order.
  - WORD_COUNT=5; ECHO_DONE pulses once, 1 cycle after FIFO_EN falls; OVERFLOW=0.
- Odd window: FIFO_EN high 7 cycles with ADC_DATA=0x100..0x106.
  - Required: 4 words, the last being 0x00000106, pushed on the ECHO_DONE edge; WORD_COUNT=4.
- Backpressure/overflow: DEPTH_LOG2=4, OUT_READY=0, FIFO_EN high 40 cycles.
  - Required: FIFO_LEVEL saturates at 16; OVERFLOW=1; WORD_COUNT=16; the 16 stored words are the first 16 packed words.
  - Then OUT_READY=1: all 16 drain in order and OUT_VALID drops.
- Full with concurrent pop: FIFO full, OUT_READY=1 while new words arrive.
  - Required: no drop, level stays 16, OVERFLOW stays 0.
- START clears status: after the overflow case, pulse START.
  - Required: OVERFLOW=0, WORD_COUNT=0, FIFO contents unchanged.
  - A START coincident with the first FIFO_EN sample keeps that sample as the low half.
- Reset mid-capture: assert RESET after 3 samples of a window.
  - Required: next cycle OUT_VALID=0, FIFO_LEVEL=0, no ECHO_DONE.
  - A subsequent 4-sample window yields exactly 2 words.

Source files
------------

// File: rtl/adc_echo_packer.sv
// adc_echo_packer
// Captures one ADC sample per clock while FIFO_EN is high and packs two
// samples into each 32-bit word. Packed words go into an internal
// first-word-fall-through FIFO, which drains through a valid/ready stream.
// The block also reports per-echo completion, a count of words written and a
// sticky overflow flag.
//
// Ports:
//   CLK        : system clock; all logic runs on the rising edge
//   RESET      : synchronous, active-high reset
//   START      : one-cycle pulse that clears the per-acquisition status
//   FIFO_EN    : acquisition window; high means ADC_DATA is valid this cycle
//   ADC_DATA   : ADC sample
//   OUT_DATA   : packed word; [15:0] holds the earlier sample, [31:16] the later one
//   OUT_VALID  : OUT_DATA is valid (the FIFO is not empty)
//   OUT_READY  : the consumer takes OUT_DATA when OUT_VALID & OUT_READY
//   WORD_COUNT : words written into the FIFO since the last START/RESET
//   OVERFLOW   : sticky; at least one word was dropped since the last START/RESET
//   ECHO_DONE  : one-cycle pulse at the end of each FIFO_EN window
//   FIFO_LEVEL : current FIFO occupancy
module adc_echo_packer #(
    parameter int ADC_DATA_WIDTH = 12,
    parameter int DEPTH_LOG2     = 4,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      START,
    input  logic                      FIFO_EN,
    input  logic [ADC_DATA_WIDTH-1:0] ADC_DATA,
    output logic [31:0]               OUT_DATA,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [COUNT_WIDTH-1:0]    WORD_COUNT,
    output logic                      OVERFLOW,
    output logic                      ECHO_DONE,
    output logic [DEPTH_LOG2:0]       FIFO_LEVEL
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [0:0] {
        PK_EMPTY = 1'b0,
        PK_HALF  = 1'b1
    } pk_state_t;

    pk_state_t                 pk_state_q, pk_state_d;
    logic [15:0]               held_q, held_d;
    logic                      fifo_en_dly_q, fifo_en_dly_d;
    logic                      echo_done_q, echo_done_d;
    logic [COUNT_WIDTH-1:0]    word_count_q, word_count_d;
    logic                      overflow_q, overflow_d;
    logic [DEPTH_LOG2:0]       level_q, level_d;
    logic [DEPTH_LOG2-1:0]     wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]     rd_ptr_q, rd_ptr_d;
    logic [31:0]               mem [DEPTH];

    logic [15:0]               sample_s;
    logic                      push_req_s;
    logic [31:0]               push_word_s;
    logic                      pop_s;
    logic                      full_s;
    logic                      push_ok_s;
    logic                      drop_s;

    // Packer next state: pairs samples, flushes a lone half-word at window end
    always_comb begin
        sample_s      = 16'(ADC_DATA);
        pk_state_d    = pk_state_q;
        held_d        = held_q;
        push_req_s    = 1'b0;
        push_word_s   = 32'h0000_0000;
        fifo_en_dly_d = FIFO_EN;
        echo_done_d   = fifo_en_dly_q & ~FIFO_EN;
        if (FIFO_EN) begin
            case (pk_state_q)
                PK_EMPTY: begin
                    held_d     = sample_s;
                    pk_state_d = PK_HALF;
                end
                PK_HALF: begin
                    push_req_s  = 1'b1;
                    push_word_s = {sample_s, held_q};
                    pk_state_d  = PK_EMPTY;
                end
                default: begin
                    pk_state_d = PK_EMPTY;
                end
            endcase
        end else if (fifo_en_dly_q && (pk_state_q == PK_HALF)) begin
            push_req_s  = 1'b1;
            push_word_s = {16'h0000, held_q};
            pk_state_d  = PK_EMPTY;
        end else begin
            pk_state_d = pk_state_q;
        end
        // START restarts packing; a sample on the same edge becomes the new low half
        if (START) begin
            if (FIFO_EN) begin
                held_d     = sample_s;
                pk_state_d = PK_HALF;
            end else begin
                pk_state_d = PK_EMPTY;
            end
        end else begin
            held_d = held_d;
        end
    end

    // FIFO control: a full FIFO still accepts a push when a pop frees a slot on the same edge
    always_comb begin
        pop_s     = (level_q != '0) & OUT_READY;
        full_s    = (level_q == FULL_LEVEL);
        push_ok_s = push_req_s & (~full_s | pop_s);
        drop_s    = push_req_s & full_s & ~pop_s;
        wr_ptr_d  = push_ok_s ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d  = pop_s ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        case ({push_ok_s, pop_s})
            2'b10:   level_d = level_q + (DEPTH_LOG2+1)'(1);
            2'b01:   level_d = level_q - (DEPTH_LOG2+1)'(1);
            default: level_d = level_q;
        endcase
        if (START) begin
            word_count_d = '0;
            overflow_d   = 1'b0;
        end else begin
            word_count_d = push_ok_s ? word_count_q + COUNT_WIDTH'(1) : word_count_q;
            overflow_d   = overflow_q | drop_s;
        end
    end

    // State and status registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pk_state_q    <= PK_EMPTY;
            held_q        <= 16'h0000;
            fifo_en_dly_q <= 1'b0;
            echo_done_q   <= 1'b0;
            word_count_q  <= '0;
            overflow_q    <= 1'b0;
            level_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            pk_state_q    <= pk_state_d;
            held_q        <= held_d;
            fifo_en_dly_q <= fifo_en_dly_d;
            echo_done_q   <= echo_done_d;
            word_count_q  <= word_count_d;
            overflow_q    <= overflow_d;
            level_q       <= level_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            mem[wr_ptr_q] <= push_word_s;
        end
    end

    // Outputs; OUT_DATA is forced to zero while empty so that no stale entry shows
    always_comb begin
        OUT_VALID  = (level_q != '0);
        OUT_DATA   = OUT_VALID ? mem[rd_ptr_q] : 32'h0000_0000;
        WORD_COUNT = word_count_q;
        OVERFLOW   = overflow_q;
        ECHO_DONE  = echo_done_q;
        FIFO_LEVEL = level_q;
    end

endmodule
